// File: rtl/sprite_render.sv
`default_nettype none
// ============================================================================
// Module      : sprite_render
// Description : Sprite pixel stage. Captures attribute, X and pattern bytes
//               for up to eight sprites during the fetch window, then counts
//               down X and shifts pattern bits out each visible dot, emitting
//               the highest-priority (lowest slot) opaque sprite pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_render #(
    parameter int NSLOT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rend,
    input  logic [8:0] cycle,
    input  logic [8:0] scan,
    input  logic [7:0] ppumask,
    input  logic [3:0] sprite_cnt,
    input  logic [7:0] attribute,
    input  logic [7:0] x,
    input  logic       sp0,
    input  logic [7:0] pat_data,
    output logic [3:0] sp_pix,
    output logic       sp_pri,
    output logic       sp_zero
);

    // Slot state. attr keeps only the bits used downstream: {priority, palette}.
    logic [7:0] pat_lo_q [NSLOT];
    logic [7:0] pat_lo_d [NSLOT];
    logic [7:0] pat_hi_q [NSLOT];
    logic [7:0] pat_hi_d [NSLOT];
    logic [2:0] attr_q   [NSLOT];
    logic [2:0] attr_d   [NSLOT];
    logic [7:0] xcnt_q   [NSLOT];
    logic [7:0] xcnt_d   [NSLOT];
    logic       sp0_line_q;
    logic       sp0_line_d;

    logic       w_load_win;
    logic       w_render;
    logic       w_show;
    logic [2:0] w_slot;
    logic [2:0] w_c8;
    logic       w_slot_valid;
    logic [7:0] w_pat_flip;
    logic [7:0] w_pat_in;
    logic       w_found;
    logic [1:0] w_px_k;
    logic       w_unused;

    // Fetch window covers dots 256..319, one 8-dot group per slot.
    assign w_load_win   = rend && (cycle >= 9'd256) && (cycle <= 9'd319);
    // Visible dots 1..256 on scanlines 0..239 shift/count the slots.
    assign w_render     = rend && (cycle >= 9'd1) && (cycle <= 9'd256) && (scan <= 9'd239);
    // Pixel px = cycle-1, so px < 8 corresponds to cycle <= 8.
    assign w_show       = w_render && ppumask[4] && (ppumask[2] || (cycle > 9'd8));
    assign w_slot       = cycle[5:3];
    assign w_c8         = cycle[2:0];
    assign w_slot_valid = ({1'b0, w_slot} < sprite_cnt);
    // Slots beyond the found-sprite count are forced transparent.
    assign w_pat_in     = w_slot_valid ? (attribute[6] ? w_pat_flip : pat_data) : 8'h00;
    // Mask and attribute bits that this stage does not consume.
    assign w_unused     = ^{ppumask[7:5], ppumask[3], ppumask[1:0], attribute[7], attribute[4:2]};

    // Horizontal flip: bit-reverse the fetched pattern byte.
    always_comb begin
        w_pat_flip = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_pat_flip[i] = pat_data[7-i];
        end
    end

    // Next-state: shift/count during render, capture slot data in the fetch window.
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            pat_lo_d[k] = pat_lo_q[k];
            pat_hi_d[k] = pat_hi_q[k];
            attr_d[k]   = attr_q[k];
            xcnt_d[k]   = xcnt_q[k];
            if (w_render) begin
                if (xcnt_q[k] == 8'd0) begin
                    pat_lo_d[k] = {pat_lo_q[k][6:0], 1'b0};
                    pat_hi_d[k] = {pat_hi_q[k][6:0], 1'b0};
                end else begin
                    xcnt_d[k] = xcnt_q[k] - 8'd1;
                end
            end
        end
        sp0_line_d = sp0_line_q;
        if (w_load_win) begin
            if (cycle == 9'd256) begin
                sp0_line_d = sp0;
            end
            if (w_c8 == 3'd5) begin
                attr_d[w_slot]   = {attribute[5], attribute[1:0]};
                xcnt_d[w_slot]   = x;
                pat_lo_d[w_slot] = w_pat_in;
            end
            if (w_c8 == 3'd7) begin
                pat_hi_d[w_slot] = w_pat_in;
            end
        end
    end

    // Slot and sprite-0 registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSLOT; k++) begin
                pat_lo_q[k] <= 8'h00;
                pat_hi_q[k] <= 8'h00;
                attr_q[k]   <= 3'd0;
                xcnt_q[k]   <= 8'd0;
            end
            sp0_line_q <= 1'b0;
        end else begin
            for (int k = 0; k < NSLOT; k++) begin
                pat_lo_q[k] <= pat_lo_d[k];
                pat_hi_q[k] <= pat_hi_d[k];
                attr_q[k]   <= attr_d[k];
                xcnt_q[k]   <= xcnt_d[k];
            end
            sp0_line_q <= sp0_line_d;
        end
    end

    // Priority select: first slot with an opaque pixel wins; masking zeroes the result.
    always_comb begin
        sp_pix  = 4'd0;
        sp_pri  = 1'b0;
        sp_zero = 1'b0;
        w_found = 1'b0;
        w_px_k  = 2'b00;
        for (int k = 0; k < NSLOT; k++) begin
            w_px_k = (xcnt_q[k] == 8'd0) ? {pat_hi_q[k][7], pat_lo_q[k][7]} : 2'b00;
            if (!w_found && (w_px_k != 2'b00)) begin
                w_found = 1'b1;
                if (w_show) begin
                    sp_pix  = {attr_q[k][1:0], w_px_k};
                    sp_pri  = attr_q[k][2];
                    sp_zero = (k == 0) && sp0_line_q;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_render
// Description : Self-checking bench for sprite_render. Drives whole scanlines
//               of dots, keeps a positional sprite model, and compares every
//               cycle plus a set of hand-computed pixel expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_render;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rend = 1'b0;
    logic [8:0] cycle = 9'd0;
    logic [8:0] scan = 9'd0;
    logic [7:0] ppumask = 8'h00;
    logic [3:0] sprite_cnt = 4'd0;
    logic [7:0] attribute = 8'h00;
    logic [7:0] x = 8'h00;
    logic       sp0 = 1'b0;
    logic [7:0] pat_data = 8'h00;
    logic [3:0] sp_pix;
    logic       sp_pri;
    logic       sp_zero;

    sprite_render #(.NSLOT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rend       (rend),
        .cycle      (cycle),
        .scan       (scan),
        .ppumask    (ppumask),
        .sprite_cnt (sprite_cnt),
        .attribute  (attribute),
        .x          (x),
        .sp0        (sp0),
        .pat_data   (pat_data),
        .sp_pix     (sp_pix),
        .sp_pri     (sp_pri),
        .sp_zero    (sp_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Sprite table presented by the OAM stage during the current line.
    logic [7:0] t_attr [8];
    logic [7:0] t_x    [8];
    logic [7:0] t_lo   [8];
    logic [7:0] t_hi   [8];
    logic [3:0] t_cnt;
    logic       t_sp0;

    // Model: sprites in effect for the line being rendered.
    logic [7:0] m_attr [8];
    logic [7:0] m_x    [8];
    logic [7:0] m_lo   [8];
    logic [7:0] m_hi   [8];
    logic       m_sp0;
    int         rcount;

    int lit_pix  [256];
    int lit_pri  [256];
    int lit_zero [256];

    logic [3:0] e_pix;
    logic       e_pri;
    logic       e_zero;
    logic [1:0] e_p;
    bit         e_found;
    int         e_px;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Pixel of sprite k after rcount render dots: visible for 8 dots starting at X.
    function automatic logic [1:0] slot_pix(input int k);
        int off;
        off = rcount - int'(m_x[k]);
        if (off >= 0 && off < 8) return {m_hi[k][7-off], m_lo[k][7-off]};
        return 2'b00;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t scan=%0d cycle=%0d: got %0h expected %0h",
                     name, $time, scan, cycle, act, exp);
        end
    endtask

    // Compare process: model expectation every cycle, literal pins where set.
    always @(negedge clk) begin
        if (chk_on) begin
            e_pix   = 4'd0;
            e_pri   = 1'b0;
            e_zero  = 1'b0;
            e_found = 1'b0;
            if (!rst && rend && cycle >= 9'd1 && cycle <= 9'd256 && scan <= 9'd239) begin
                for (int k = 0; k < 8; k++) begin
                    e_p = slot_pix(k);
                    if (!e_found && e_p != 2'b00) begin
                        e_found = 1'b1;
                        if (ppumask[4] && !(cycle <= 9'd8 && !ppumask[2])) begin
                            e_pix  = {m_attr[k][1:0], e_p};
                            e_pri  = m_attr[k][5];
                            e_zero = (k == 0) && m_sp0;
                        end
                    end
                end
            end
            chk("sp_pix", int'(sp_pix), int'(e_pix));
            chk("sp_pri", int'(sp_pri), int'(e_pri));
            chk("sp_zero", int'(sp_zero), int'(e_zero));
            if (cycle >= 9'd1 && cycle <= 9'd256) begin
                e_px = int'(cycle) - 1;
                if (lit_pix[e_px]  >= 0) chk("lit_pix",  int'(sp_pix),  lit_pix[e_px]);
                if (lit_pri[e_px]  >= 0) chk("lit_pri",  int'(sp_pri),  lit_pri[e_px]);
                if (lit_zero[e_px] >= 0) chk("lit_zero", int'(sp_zero), lit_zero[e_px]);
            end
        end
    end

    task automatic clear_lit();
        for (int i = 0; i < 256; i++) begin
            lit_pix[i] = -1; lit_pri[i] = -1; lit_zero[i] = -1;
        end
    endtask

    task automatic lit(input int px, input int p, input int pr, input int z);
        lit_pix[px] = p; lit_pri[px] = pr; lit_zero[px] = z;
    endtask

    // Unused slots carry opaque data at X=0 so a missed transparency shows at px0.
    task automatic tbl_default(input int cnt, input logic s0);
        for (int k = 0; k < 8; k++) begin
            t_attr[k] = 8'h00; t_x[k] = 8'h00; t_lo[k] = 8'hFF; t_hi[k] = 8'hFF;
        end
        t_cnt = 4'(cnt);
        t_sp0 = s0;
    endtask

    task automatic set_slot(input int k, input logic [7:0] a, input logic [7:0] xx,
                            input logic [7:0] lo, input logic [7:0] hi);
        t_attr[k] = a; t_x[k] = xx; t_lo[k] = lo; t_hi[k] = hi;
    endtask

    // One full scanline of dots 0..340; rst_at/pause_* < 0 or out of range disable.
    task automatic run_line(input int sc, input int rst_at, input int pause_lo, input int pause_hi);
        int k;
        for (int c = 0; c <= 340; c++) begin
            @(posedge clk); #1;
            if (!rst && rend && cycle >= 9'd1 && cycle <= 9'd256 && scan <= 9'd239) rcount++;
            if (c == 0) rcount = 0;
            scan  = 9'(sc);
            cycle = 9'(c);
            rend  = !(c >= pause_lo && c <= pause_hi);
            if (c == rst_at) begin
                rst = 1'b1;
                for (int j = 0; j < 8; j++) begin
                    m_attr[j] = 8'h00; m_x[j] = 8'h00; m_lo[j] = 8'h00; m_hi[j] = 8'h00;
                end
                m_sp0 = 1'b0;
            end
            if (rst_at >= 0 && c == rst_at + 4) rst = 1'b0;
            if (c >= 256 && c <= 319) begin
                k = (c >> 3) & 7;
                attribute = t_attr[k];
                x         = t_x[k];
                pat_data  = ((c >> 1) & 1) != 0 ? t_hi[k] : t_lo[k];
            end else begin
                attribute = 8'h00;
                x         = 8'h00;
                pat_data  = 8'h00;
            end
            sp0        = t_sp0;
            sprite_cnt = t_cnt;
        end
        @(posedge clk); #1;
        // The sprites fetched on this line are the ones rendered on the next.
        for (int j = 0; j < 8; j++) begin
            m_attr[j] = t_attr[j];
            m_x[j]    = t_x[j];
            if (j < int'(t_cnt)) begin
                m_lo[j] = t_attr[j][6] ? rev8(t_lo[j]) : t_lo[j];
                m_hi[j] = t_attr[j][6] ? rev8(t_hi[j]) : t_hi[j];
            end else begin
                m_lo[j] = 8'h00;
                m_hi[j] = 8'h00;
            end
        end
        m_sp0 = t_sp0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            m_attr[k] = 8'h00; m_x[k] = 8'h00; m_lo[k] = 8'h00; m_hi[k] = 8'h00;
        end
        m_sp0  = 1'b0;
        rcount = 0;
        clear_lit();
        tbl_default(0, 1'b0);

        #2 rst = 1'b1;
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Pre-render line fetches a single sprite: X=10, lo=F0, palette 3.
        ppumask = 8'h1E;
        tbl_default(1, 1'b0);
        set_slot(0, 8'h03, 8'd10, 8'hF0, 8'h00);
        run_line(261, -10, -10, -10);

        // Line 0: px10..13 = D, px14..17 transparent; unused slots stay clear at px0.
        clear_lit();
        lit(0, 0, 0, 0);
        for (int p = 10; p <= 13; p++) lit(p, 4'hD, 0, 0);
        for (int p = 14; p <= 17; p++) lit(p, 0, 0, 0);
        tbl_default(1, 1'b0);
        set_slot(0, 8'h40, 8'd0, 8'h01, 8'h00);
        run_line(0, -10, -10, -10);

        // Line 1: flipped 01 at X=0 shows only at px0.
        ppumask = 8'h14;
        clear_lit();
        lit(0, 4'h1, 0, 0);
        for (int p = 1; p <= 7; p++) lit(p, 0, 0, 0);
        tbl_default(2, 1'b0);
        set_slot(0, 8'h00, 8'd20, 8'h00, 8'h00);
        set_slot(1, 8'h21, 8'd20, 8'hFF, 8'h00);
        run_line(1, -10, -10, -10);

        // Line 2: transparent slot 0 lets slot 1 through with priority set.
        clear_lit();
        lit(20, 4'h5, 1, 0);
        tbl_default(2, 1'b1);
        set_slot(0, 8'h02, 8'd20, 8'hFF, 8'hFF);
        set_slot(1, 8'h21, 8'd20, 8'hFF, 8'h00);
        run_line(2, -10, -10, -10);

        // Line 3: opaque slot 0 holding sprite 0 wins.
        clear_lit();
        lit(20, 4'hB, 0, 1);
        tbl_default(1, 1'b0);
        set_slot(0, 8'h00, 8'd0, 8'hFF, 8'h00);
        run_line(3, -10, -10, -10);

        // Line 4: left 8 pixels clipped.
        ppumask = 8'h10;
        clear_lit();
        for (int p = 0; p <= 8; p++) lit(p, 0, 0, 0);
        run_line(4, -10, -10, -10);

        // Line 5: left clip off, px0 visible.
        ppumask = 8'h14;
        clear_lit();
        lit(0, 4'h1, 0, 0);
        tbl_default(3, 1'b0);
        set_slot(0, 8'h01, 8'd255, 8'h80, 8'h80);
        set_slot(1, 8'h02, 8'd100, 8'h0F, 8'h00);
        set_slot(2, 8'h00, 8'd50, 8'h00, 8'h00);
        run_line(5, -10, -10, -10);

        // Line 6: slots 3..7 transparent, X=255 sprite only at px255.
        clear_lit();
        lit(0, 0, 0, 0);
        lit(1, 0, 0, 0);
        lit(103, 0, 0, 0);
        lit(104, 4'h9, 0, 0);
        lit(254, 0, 0, 0);
        lit(255, 4'h7, 0, 0);
        tbl_default(1, 1'b0);
        set_slot(0, 8'h03, 8'd95, 8'hFF, 8'h00);
        run_line(6, -10, -10, -10);

        // Line 7: reset at cycle 100 (px99) blanks the output in that same cycle.
        clear_lit();
        for (int p = 95; p <= 98; p++) lit(p, 4'hD, 0, 0);
        for (int p = 99; p <= 110; p++) lit(p, 0, 0, 0);
        tbl_default(1, 1'b0);
        set_slot(0, 8'h00, 8'd30, 8'hFF, 8'hFF);
        run_line(7, 100, -10, -10);

        // Line 8: rendering paused for dots 20..29 delays the sprite by 10 px.
        clear_lit();
        lit(19, 0, 0, 0);
        lit(25, 0, 0, 0);
        lit(39, 0, 0, 0);
        lit(40, 4'h3, 0, 0);
        lit(47, 4'h3, 0, 0);
        lit(48, 0, 0, 0);
        run_line(8, -10, 20, 29);

        // Post-render line: outputs stay zero.
        clear_lit();
        lit(30, 0, 0, 0);
        run_line(240, -10, -10, -10);

        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
